// File: rtl/branch_predictor.sv
// Tagged, direct-mapped branch history table of 2-bit saturating counters.
// Provides a zero-latency taken/not-taken guess to fetch, trains on resolved
// outcomes from execute, flags mispredictions for flush, and keeps wrapping
// branch / misprediction counters for the performance-counter path.
module branch_predictor #(
  parameter int PC_WIDTH   = 32,
  parameter int LINES      = 8,
  parameter int INDEX_BITS = $clog2(LINES),
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 guess_valid,
  input  logic [PC_WIDTH-1:0]  guess_pc,
  output logic                 guess_taken,
  input  logic                 check_valid,
  input  logic [PC_WIDTH-1:0]  check_pc,
  input  logic                 check_taken,
  input  logic                 check_pred,
  output logic                 mispredict,
  input  logic                 stat_clear,
  output logic [CNT_WIDTH-1:0] br_count,
  output logic [CNT_WIDTH-1:0] mispred_count
);

  localparam int TAG_BITS = PC_WIDTH - INDEX_BITS - 2;

  // Counter encoding: MSB is the taken/not-taken prediction.
  typedef enum logic [1:0] {
    CTR_STRONG_NT = 2'b00,
    CTR_WEAK_NT   = 2'b01,
    CTR_WEAK_T    = 2'b10,
    CTR_STRONG_T  = 2'b11
  } ctr_e;

  // Saturating step of a counter toward the resolved outcome.
  function automatic ctr_e ctr_step(input ctr_e cur, input logic taken);
    ctr_e nxt;
    nxt = cur;
    case (cur)
      CTR_STRONG_NT: nxt = taken ? CTR_WEAK_NT  : CTR_STRONG_NT;
      CTR_WEAK_NT:   nxt = taken ? CTR_WEAK_T   : CTR_STRONG_NT;
      CTR_WEAK_T:    nxt = taken ? CTR_STRONG_T : CTR_WEAK_NT;
      CTR_STRONG_T:  nxt = taken ? CTR_STRONG_T : CTR_WEAK_T;
      default:       nxt = CTR_WEAK_NT;
    endcase
    return nxt;
  endfunction

  // Table state
  logic                r_valid [LINES];
  logic [TAG_BITS-1:0] r_tag   [LINES];
  ctr_e                r_ctr   [LINES];

  // Statistics state
  logic [CNT_WIDTH-1:0] r_br_count;
  logic [CNT_WIDTH-1:0] r_mispred_count;

  // Address decode for both ports
  logic [INDEX_BITS-1:0] w_guess_idx;
  logic [TAG_BITS-1:0]   w_guess_tag;
  logic [INDEX_BITS-1:0] w_chk_idx;
  logic [TAG_BITS-1:0]   w_chk_tag;
  logic                  w_guess_hit;
  logic                  w_chk_hit;
  logic                  w_unused_pc_lsbs;

  assign w_guess_idx = guess_pc[INDEX_BITS+1:2];
  assign w_guess_tag = guess_pc[PC_WIDTH-1:INDEX_BITS+2];
  assign w_chk_idx   = check_pc[INDEX_BITS+1:2];
  assign w_chk_tag   = check_pc[PC_WIDTH-1:INDEX_BITS+2];

  // Instructions are word aligned; the byte offset never selects an entry.
  assign w_unused_pc_lsbs = ^{guess_pc[1:0], check_pc[1:0]};

  // Lookup: reads the pre-edge table, so a same-cycle update to the same
  // index is not visible until the following cycle. Qualifying with the
  // valid strobes keeps X on an idle PC from reaching the outputs.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_guess_hit = 1'b0;
    w_chk_hit   = 1'b0;
    guess_taken = 1'b0;
    if (guess_valid) begin
      w_guess_hit = r_valid[w_guess_idx] && (r_tag[w_guess_idx] == w_guess_tag);
      guess_taken = w_guess_hit && r_ctr[w_guess_idx][1];
    end
    if (check_valid) begin
      w_chk_hit = r_valid[w_chk_idx] && (r_tag[w_chk_idx] == w_chk_tag);
    end
  end

  // Misprediction flag goes straight to the flush logic, unregistered.
  assign mispredict = check_valid && (check_pred != check_taken);

  // Valid bits and counters: reset to invalid / weakly not-taken; train on hit,
  // allocate on miss. The loop compares indices rather than indexing with
  // check_pc so that an idle (possibly X) PC can never select an entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LINES; i++) begin
      if (!rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= CTR_WEAK_NT;
      end else if (check_valid && (w_chk_idx == INDEX_BITS'(i))) begin
        r_valid[i] <= 1'b1;
        if (w_chk_hit) begin
          r_ctr[i] <= ctr_step(r_ctr[i], check_taken);
        end else begin
          r_ctr[i] <= check_taken ? CTR_WEAK_T : CTR_WEAK_NT;
        end
      end
    end
  end

  // Tags are written on allocation only.
  always_ff @(posedge clk) begin
    // NOTE: the tag array is deliberately not reset; a cleared valid bit makes
    // its contents irrelevant and keeps the array a plain RAM.
    if (rst && check_valid && !w_chk_hit) begin
      r_tag[w_chk_idx] <= w_chk_tag;
    end
  end

  // Statistics: wrap modulo 2^CNT_WIDTH; clear wins over a concurrent count.
  always_ff @(posedge clk) begin
    if (!rst || stat_clear) begin
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else if (check_valid) begin
      r_br_count <= r_br_count + 1'b1;
      if (mispredict) begin
        r_mispred_count <= r_mispred_count + 1'b1;
      end
    end
  end

  assign br_count      = r_br_count;
  assign mispred_count = r_mispred_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios followed by random traffic,
// all compared against a table model built from the counter/allocate rules.
// A second instance with 4-bit statistics exercises counter wrap-around.
module tb_branch_predictor;

  localparam int PW    = 32;
  localparam int LINES = 8;
  localparam int SCW   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           guess_valid;
  logic [PW-1:0]  guess_pc;
  logic           check_valid;
  logic [PW-1:0]  check_pc;
  logic           check_taken;
  logic           check_pred;
  logic           stat_clear;
  logic           guess_taken, guess_taken_s;
  logic           mispredict, mispredict_s;
  logic [31:0]    br_count, mispred_count;
  logic [SCW-1:0] br_count_s, mispred_count_s;

  branch_predictor #(.PC_WIDTH(PW), .LINES(LINES), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .guess_valid(guess_valid), .guess_pc(guess_pc), .guess_taken(guess_taken),
    .check_valid(check_valid), .check_pc(check_pc), .check_taken(check_taken),
    .check_pred(check_pred), .mispredict(mispredict), .stat_clear(stat_clear),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  branch_predictor #(.PC_WIDTH(PW), .LINES(LINES), .CNT_WIDTH(SCW)) dut_s (
    .clk(clk), .rst(rst),
    .guess_valid(guess_valid), .guess_pc(guess_pc), .guess_taken(guess_taken_s),
    .check_valid(check_valid), .check_pc(check_pc), .check_taken(check_taken),
    .check_pred(check_pred), .mispredict(mispredict_s), .stat_clear(stat_clear),
    .br_count(br_count_s), .mispred_count(mispred_count_s)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference model: per-line presence, owning address and confidence 0..3.
  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];
  int          m_conf  [LINES];
  longint      m_br, m_mis;

  function automatic int idx_of(input logic [PW-1:0] pc);
    return int'(pc / 4) % LINES;
  endfunction

  function automatic int unsigned tag_of(input logic [PW-1:0] pc);
    return int'(pc / (4 * LINES));
  endfunction

  function automatic bit m_guess(input bit v, input logic [PW-1:0] pc);
    int i;
    if (!v) return 1'b0;
    i = idx_of(pc);
    return m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_conf[i] >= 2);
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_conf[i]  = 1;
    end
    m_br  = 0;
    m_mis = 0;
  endfunction

  function automatic void m_clock(input bit r, input bit cv, input logic [PW-1:0] cpc,
                                  input bit ct, input bit cp, input bit sc);
    int i;
    if (!r) begin
      m_reset();
      return;
    end
    if (sc) begin
      m_br = 0; m_mis = 0;
    end else if (cv) begin
      m_br++;
      if (cp != ct) m_mis++;
    end
    if (cv) begin
      i = idx_of(cpc);
      if (m_valid[i] && m_tag[i] == tag_of(cpc)) begin
        m_conf[i] = ct ? ((m_conf[i] + 1 > 3) ? 3 : m_conf[i] + 1)
                       : ((m_conf[i] - 1 < 0) ? 0 : m_conf[i] - 1);
      end else begin
        m_valid[i] = 1'b1;
        m_tag[i]   = tag_of(cpc);
        m_conf[i]  = ct ? 2 : 1;
      end
    end
  endfunction

  // One cycle: drive, check combinational and registered outputs mid-cycle,
  // then clock and advance the model. Idle PCs are driven to X.
  task automatic step(input bit r, input bit gv, input logic [PW-1:0] gpc,
                      input bit cv, input logic [PW-1:0] cpc, input bit ct,
                      input bit cp, input bit sc);
    logic [31:0] exp_br, exp_mis;
    rst         = r;
    guess_valid = gv;
    guess_pc    = gv ? gpc : 'x;
    check_valid = cv;
    check_pc    = cv ? cpc : 'x;
    check_taken = ct;
    check_pred  = cp;
    stat_clear  = sc;
    #3;
    exp_br  = 32'(m_br);
    exp_mis = 32'(m_mis);
    check("guess",      {31'd0, guess_taken},   {31'd0, m_guess(gv, gpc)});
    check("guess_s",    {31'd0, guess_taken_s}, {31'd0, m_guess(gv, gpc)});
    check("mispredict", {31'd0, mispredict},    {31'd0, cv && (cp != ct)});
    check("br_count",   br_count,               exp_br);
    check("mis_count",  mispred_count,          exp_mis);
    check("br_wrap",    {28'd0, br_count_s},      {28'd0, exp_br[SCW-1:0]});
    check("mis_wrap",   {28'd0, mispred_count_s}, {28'd0, exp_mis[SCW-1:0]});
    @(posedge clk);
    m_clock(r, cv, cpc, ct, cp, sc);
    #1;
  endtask

  // Lookup-only cycle with an explicit expected guess.
  task automatic look(input string tag, input logic [PW-1:0] pc, input bit exp);
    rst = 1'b1; guess_valid = 1'b1; guess_pc = pc;
    check_valid = 1'b0; check_pc = 'x; stat_clear = 1'b0;
    #2;
    check(tag, {31'd0, guess_taken}, {31'd0, exp});
    step(1, 1, pc, 0, 0, 0, 0, 0);
  endtask

  task automatic train(input logic [PW-1:0] pc, input bit taken);
    step(1, 0, 0, 1, pc, taken, taken, 0);
  endtask

  logic [PW-1:0] gpc, cpc;

  initial begin
    rst = 1'b0; guess_valid = 1'b0; guess_pc = '0; check_valid = 1'b0;
    check_pc = '0; check_taken = 1'b0; check_pred = 1'b0; stat_clear = 1'b0;
    repeat (2) @(posedge clk);
    m_reset();
    #1;

    // After reset: miss and zeroed statistics
    look("reset_guess", 32'h0000_1000, 1'b0);
    check("reset_br",  br_count,      32'd0);
    check("reset_mis", mispred_count, 32'd0);

    // First taken resolution, predicted not-taken -> mispredict, allocate 10
    rst = 1'b1; check_valid = 1'b1; check_pc = 32'h1000;
    check_taken = 1'b1; check_pred = 1'b0; guess_valid = 1'b0; stat_clear = 1'b0;
    #2;
    check("first_mispredict", {31'd0, mispredict}, 32'd1);
    step(1, 0, 0, 1, 32'h1000, 1, 0, 0);
    look("alloc_taken", 32'h1000, 1'b1);
    check("first_br",  br_count,      32'd1);
    check("first_mis", mispred_count, 32'd1);

    // Saturate, then walk back down
    repeat (3) train(32'h1000, 1);
    train(32'h1000, 0);
    look("sat_down_one", 32'h1000, 1'b1);
    train(32'h1000, 0);
    look("sat_down_two", 32'h1000, 1'b0);

    // Alias on the same index with a different tag
    train(32'h1000, 1); train(32'h1000, 1);
    look("alias_owner", 32'h1000, 1'b1);
    look("alias_miss",  32'h1020, 1'b0);
    train(32'h1020, 0);
    look("alias_evicted", 32'h1000, 1'b0);

    // Same-cycle lookup/update: old state visible, new state next cycle
    train(32'h2000, 1);
    rst = 1'b1; guess_valid = 1'b1; guess_pc = 32'h2000; check_valid = 1'b1;
    check_pc = 32'h2000; check_taken = 1'b1; check_pred = 1'b1; stat_clear = 1'b0;
    #2;
    check("rbw_old", {31'd0, guess_taken}, 32'd1);
    step(1, 1, 32'h2000, 1, 32'h2000, 1, 1, 0);
    train(32'h2000, 0);
    look("rbw_new_sat", 32'h2000, 1'b1);

    // Clear races a check; then reset races a check
    step(1, 0, 0, 1, 32'h3000, 1, 0, 1);
    check("clear_br",  br_count,      32'd0);
    check("clear_mis", mispred_count, 32'd0);
    step(0, 0, 0, 1, 32'h3004, 1, 1, 0);
    look("reset_no_alloc", 32'h3004, 1'b0);
    check("reset_no_count", br_count, 32'd0);

    // Random traffic over a small address pool to provoke hits and aliases
    for (int n = 0; n < 3000; n++) begin
      gpc = {$urandom_range(0, 3), 3'($urandom), 2'($urandom)} + 32'h4000_0000;
      cpc = {$urandom_range(0, 3), 3'($urandom), 2'($urandom)} + 32'h4000_0000;
      step(($urandom_range(0, 199) != 0), $urandom_range(0, 3) != 0, gpc,
           $urandom_range(0, 3) != 0, cpc, 1'($urandom), 1'($urandom),
           $urandom_range(0, 99) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Tagged, direct-mapped branch history table of 2-bit saturating counters.
- Gives the fetch stage a taken/not-taken guess for each conditional branch PC.
- Sits downstream of the execute-stage branch comparator and takes its resolved outcome (BrTaken) to train the table and flag mispredictions for the flush logic.
- Keeps saturating-free wrap-around statistics counters for the CSR/perf path.

Parameters:
- PC_WIDTH, 32, instruction address width.
- LINES, 8, number of table entries; must be a power of 2, >= 2.
- INDEX_BITS, $clog2(LINES), derived; not overridden.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset (rst==0 at a rising edge resets).
- guess_valid  input  1  fetch stage presents a branch PC this cycle.
- guess_pc  input  PC_WIDTH  PC of the branch being fetched.
- guess_taken  output  1  combinational prediction for guess_pc.
- check_valid  input  1  execute stage resolves a conditional branch this cycle.
- check_pc  input  PC_WIDTH  PC of the resolving branch.
- check_taken  input  1  actual outcome from the branch comparator.
- check_pred  input  1  prediction originally issued for this branch, piped down.
- mispredict  output  1  combinational; check_valid & (check_pred != check_taken).
- stat_clear  input  1  synchronous clear of both statistics counters.
- br_count  output  CNT_WIDTH  number of resolved branches.
- mispred_count  output  CNT_WIDTH  number of mispredicted branches.

Behaviour:
- Addressing:
  - index = pc[INDEX_BITS+1:2].
  - tag = pc[PC_WIDTH-1:INDEX_BITS+2].
  - pc[1:0] are ignored.
- Entry state: valid bit, tag, 2-bit counter.
  - Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Lookup (combinational, zero latency):
  - Hit = valid & tag match.
  - guess_taken = hit & counter[1].
  - guess_taken = 0 on a miss or when guess_valid==0.
- Update (on clock edge when check_valid==1):
  - Hit, check_taken=1: counter = min(counter+1, 11).
  - Hit, check_taken=0: counter = max(counter-1, 00).
  - Miss: allocate and overwrite the entry. valid=1, tag=check tag, counter = check_taken ? 10 : 01.
- Read-before-write: when a lookup and an update target the same index in the same cycle, guess_taken reflects the pre-edge contents.
- Updates to different indices in consecutive cycles are independent. Back-to-back updates to one index accumulate (01 -> 10 -> 11).
- mispredict:
  - Purely combinational; never registered here.
  - 0 whenever check_valid==0, regardless of other inputs.
- Statistics (on clock edge):
  - check_valid: br_count += 1.
  - check_valid & mispredict: mispred_count += 1.
  - Both wrap modulo 2^CNT_WIDTH; no saturation.
  - stat_clear overrides increments in the same cycle: counters go to 0.
- Reset (rst==0 at an edge):
  - All valid bits cleared; all counters set to 01; tags don't-care; br_count = mispred_count = 0.
  - Reset overrides a concurrent check_valid: no entry is allocated and no statistic is counted.
  - After reset every lookup misses, so guess_taken=0.
  - Reset asserted mid-stream discards the in-flight update in that cycle.
- X-safety: with guess_valid==0 or check_valid==0, the PC inputs may be X without corrupting state or outputs.

Test Plan:
- Reset, then guess_pc=0x0000_1000, guess_valid=1 -> guess_taken=0; br_count=0, mispred_count=0.
- Check 0x1000 taken with check_pred=0 -> mispredict=1 that cycle; next cycle guess 0x1000 -> guess_taken=1 (counter 10); br_count=1, mispred_count=1.
- Saturation on 0x1000:
  - Three further taken checks -> counter saturates at 11.
  - One not-taken check -> counter 10, guess still 1.
  - Second not-taken -> counter 01, guess 0.
- Alias with LINES=8:
  - Train 0x1000 taken; 0x1020 shares the index with a different tag, so guess 0x1020 -> 0 (miss).
  - Check 0x1020 not-taken -> entry replaced; guess 0x1000 -> 0.
- Same-cycle lookup/update on 0x2000 (pre-trained to 10) with check_taken=1 -> guess_taken=1 from old state; next cycle the counter is 11.
- Statistics edge cases:
  - Preload br_count to 0xFFFF_FFFF via 2^32 checks, or a forced value in the bench; one more check -> 0x0000_0000.
  - stat_clear together with check_valid -> both counters 0.
  - rst=0 together with check_valid -> no allocation.
